cse_bubble_dmem_responder: RTL and testbench

- Data-memory responder for the CSE-BUBBLE processor's load/store port.
- The processor initiates word requests; this block accepts them, models configurable wait states, commits stores or returns load data, and flags illegal accesses.
- Sits between the processor core and the testbench-visible memory.
- Exposes a saturating count of successful accesses for simulation checks.

---
 rtl/cse_bubble_dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_cse_bubble_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cse_bubble_dmem_responder.sv
// Data-memory responder for the CSE-BUBBLE load/store port.
// Accepts one word request at a time, waits WAIT_CYCLES cycles, commits the
// store or reads the load data, then holds the response until it is taken.
//
// Handshakes: a transfer on either channel happens at a rising edge where
// valid and ready are both high. req_ready is high only in IDLE (and never
// while rst_n is low); resp_valid is high only in RESP, and the response
// fields stay stable until the response transfer happens.
module cse_bubble_dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [CNT_W-1:0]  access_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_nxt;

    // Request captured at acceptance; later input changes do not disturb it.
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              complete;
    logic              commit;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [29:0]       c_idx;
    logic              c_err;

    assign req_ready  = rst_n && (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid && req_ready;
    assign complete   = resp_valid && resp_ready;

    // Commit point: the edge that moves the FSM into RESP. With zero wait
    // states that is the accept edge itself, so the live request is used.
    always_comb begin
        commit  = 1'b0;
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        if (state == S_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            commit  = accept && (WAIT_CYCLES == 0);
        end else if (state == S_WAIT) begin
            commit  = (wait_cnt <= 4'd1);
        end
    end

    assign c_idx = c_addr[31:2];
    assign c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_idx} >= 32'(DEPTH));

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Memory write on a legal committed store; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && commit && c_we && !c_err) begin
            mem[c_idx[AW-1:0]] <= c_wdata;
        end
    end

    // Response fields: loaded at commit, cleared when the response is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err   <= c_err;
            resp_rdata <= (!c_err && !c_we) ? mem[c_idx[AW-1:0]] : '0;
        end else if (complete) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    // Saturating count of error-free completed responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            access_count <= '0;
        end else if (complete && !resp_err && (access_count != '1)) begin
            access_count <= access_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cse_bubble_dmem_responder.sv
// Bench for cse_bubble_dmem_responder: two instances (WAIT_CYCLES 2 and 0)
// run against a transaction-level model; directed tests add literal checks.
module tb_cse_bubble_dmem_responder;

    localparam int DW  = 32;
    localparam int DEP = 256;
    localparam int CW  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic          req_we     [2];
    logic [31:0]   req_addr   [2];
    logic [DW-1:0] req_wdata  [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_rdata [2];
    logic          resp_err   [2];
    logic [CW-1:0] access_count [2];

    cse_bubble_dmem_responder #(.DATA_W(DW), .DEPTH(DEP), .WAIT_CYCLES(2), .CNT_W(CW)) u_w2 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .access_count(access_count[0])
    );

    cse_bubble_dmem_responder #(.DATA_W(DW), .DEPTH(DEP), .WAIT_CYCLES(0), .CNT_W(CW)) u_w0 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .access_count(access_count[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding transaction per instance: it becomes visible as a
    // response WAIT_CYCLES edges after acceptance and leaves on the first
    // edge with resp_ready high.
    int          m_wait [2] = '{2, 0};
    bit          m_valid [2];
    bit          m_busy [2];
    bit          m_show [2];
    int          m_rem  [2];
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_data [2];
    bit          m_err  [2];
    int          m_cnt  [2];
    logic [31:0] ref_mem [2][DEP];

    function automatic void m_commit(int k);
        int unsigned idx;
        idx = m_addr[k] >> 2;
        m_show[k] = 1'b1;
        m_err[k]  = (m_addr[k][1:0] != 2'b00) || (idx >= DEP);
        m_data[k] = 32'd0;
        if (!m_err[k]) begin
            if (m_we[k]) ref_mem[k][idx] = m_wd[k];
            else         m_data[k]       = ref_mem[k][idx];
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                m_valid[k] = 1'b1;
                m_busy[k]  = 1'b0;
                m_show[k]  = 1'b0;
                m_err[k]   = 1'b0;
                m_data[k]  = 32'd0;
                m_cnt[k]   = 0;
            end else if (!m_valid[k]) begin
                // model not yet initialised by a reset
            end else if (!m_busy[k]) begin
                if (req_valid[k]) begin
                    m_busy[k] = 1'b1;
                    m_we[k]   = req_we[k];
                    m_addr[k] = req_addr[k];
                    m_wd[k]   = req_wdata[k];
                    m_rem[k]  = m_wait[k];
                    if (m_rem[k] == 0) m_commit(k);
                end
            end else if (!m_show[k]) begin
                m_rem[k]--;
                if (m_rem[k] == 0) m_commit(k);
            end else if (resp_ready[k]) begin
                m_busy[k] = 1'b0;
                m_show[k] = 1'b0;
                if (!m_err[k] && m_cnt[k] < 65535) m_cnt[k]++;
                m_err[k]  = 1'b0;
                m_data[k] = 32'd0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_valid[k]) begin
                chk($sformatf("dut%0d req_ready", k), {31'd0, req_ready[k]},
                    {31'd0, rst_n[k] && !m_busy[k]});
                chk($sformatf("dut%0d resp_valid", k), {31'd0, resp_valid[k]}, {31'd0, m_show[k]});
                chk($sformatf("dut%0d resp_rdata", k), resp_rdata[k], m_data[k]);
                chk($sformatf("dut%0d resp_err", k), {31'd0, resp_err[k]}, {31'd0, m_err[k]});
                chk($sformatf("dut%0d access_count", k), {16'd0, access_count[k]}, 32'(m_cnt[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns at the falling edge where the
    // response first shows, with the latency in cycles from the accept edge.
    task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic err);
        int n;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[k]) break;
        end
        if (n == 50) chk($sformatf("dut%0d accept timeout", k), 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_we[k]    = ~we;
        req_addr[k]  = addr ^ 32'hFFFF_FFF0;
        req_wdata[k] = ~wd;
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (resp_valid[k]) break;
        end
        if (n > 50) chk($sformatf("dut%0d resp timeout", k), 32'd0, 32'd1);
        lat = n;
        rd  = resp_rdata[k];
        err = resp_err[k];
    endtask

    task automatic finish_resp(input int k);
        int n;
        resp_ready[k] = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (!resp_valid[k]) break;
        end
        if (n == 50) chk($sformatf("dut%0d complete timeout", k), 32'd0, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        logic [31:0] rd;
        logic err;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = 32'd0; req_wdata[k] = 32'd0; resp_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("reset access_count", {16'd0, access_count[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready w2", {31'd0, req_ready[0]}, 32'd1);
        chk("post-reset req_ready w0", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk); #1;

        // Store then load, two wait states.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, err);
        chk("w2 store latency", 32'(lat), 32'd3);
        chk("w2 store rdata", rd, 32'd0);
        finish_resp(0);
        do_req(0, 1'b0, 32'h10, 32'h0, lat, rd, err);
        chk("w2 load latency", 32'(lat), 32'd3);
        chk("w2 load rdata", rd, 32'hDEADBEEF);
        chk("w2 load err", {31'd0, err}, 32'd0);
        finish_resp(0);
        chk("w2 count after 2", {16'd0, access_count[0]}, 32'd2);

        // Zero wait states.
        do_req(1, 1'b1, 32'h0, 32'h12345678, lat, rd, err);
        chk("w0 store latency", 32'(lat), 32'd1);
        finish_resp(1);
        do_req(1, 1'b0, 32'h0, 32'h0, lat, rd, err);
        chk("w0 load latency", 32'(lat), 32'd1);
        chk("w0 load rdata", rd, 32'h12345678);
        finish_resp(1);
        chk("w0 count", {16'd0, access_count[1]}, 32'd2);

        // Misaligned store, then confirm memory untouched.
        do_req(0, 1'b1, 32'h13, 32'hFFFFFFFF, lat, rd, err);
        chk("misaligned err", {31'd0, err}, 32'd1);
        chk("misaligned rdata", rd, 32'd0);
        finish_resp(0);
        chk("misaligned not counted", {16'd0, access_count[0]}, 32'd2);
        do_req(0, 1'b0, 32'h10, 32'h0, lat, rd, err);
        chk("reload after misaligned", rd, 32'hDEADBEEF);
        finish_resp(0);

        // Out-of-range load.
        do_req(0, 1'b0, 32'h400, 32'h0, lat, rd, err);
        chk("oor err", {31'd0, err}, 32'd1);
        chk("oor rdata", rd, 32'd0);
        finish_resp(0);
        chk("oor not counted", {16'd0, access_count[0]}, 32'd3);

        // Backpressure on the response channel for five cycles.
        resp_ready[0] = 1'b0;
        do_req(0, 1'b0, 32'h10, 32'h0, lat, rd, err);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid[0] = 1'b1; req_we[0] = 1'b1;
            req_addr[0] = 32'h20; req_wdata[0] = 32'(i);
            @(negedge clk);
            chk("hold resp_valid", {31'd0, resp_valid[0]}, 32'd1);
            chk("hold rdata", resp_rdata[0], 32'hDEADBEEF);
            chk("hold req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold released", {31'd0, resp_valid[0]}, 32'd0);
        chk("hold count", {16'd0, access_count[0]}, 32'd4);

        // Reset during WAIT discards the pending store.
        do_req(0, 1'b1, 32'h20, 32'hA5A5A5A5, lat, rd, err);
        finish_resp(0);
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h5A5A5A5A;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("rst rdata", resp_rdata[0], 32'd0);
        chk("rst err", {31'd0, resp_err[0]}, 32'd0);
        chk("rst count", {16'd0, access_count[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        do_req(0, 1'b0, 32'h20, 32'h0, lat, rd, err);
        chk("store discarded", rd, 32'hA5A5A5A5);
        finish_resp(0);
        chk("count restart", {16'd0, access_count[0]}, 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
